npc_seq: RTL and testbench

//   Next-PC sequencer: computes the npc fed back into the PC register from
//   the current pc.

---
 rtl/npc_seq.sv | 80 ++++++++
 tb/tb_npc_seq.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/npc_seq.sv
// Next-PC sequencer: picks the next PC from the current pc, branch/jump redirects,
// exception entry and eret return. It also holds a redirect that arrives while stalled.
module npc_seq #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_4180
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    input  logic        stall,
    input  logic        redir_valid,
    input  logic [31:0] redir_target,
    input  logic        exc,
    input  logic [31:0] exc_epc,
    input  logic        eret,
    output logic [31:0] npc,
    output logic [31:0] epc,
    output logic        exl,
    output logic        redir_pend
);

    logic        pend_valid;
    logic [31:0] pend_target;
    logic        exc_take;
    logic        eret_take;

    // A new exception is masked while already in the handler.
    assign exc_take  = exc && !exl;
    assign eret_take = eret && exl;

    always_comb begin
        // NOTE: npc gets a default before any branch so no latch is inferred.
        npc = pc + 32'd4;
        if (!reset)
            npc = RESET_PC;
        else if (exc_take)
            npc = EXC_VECTOR;
        else if (stall)
            npc = pc;
        else if (eret_take)
            npc = epc;
        else if (pend_valid)
            npc = pend_target;
        else if (redir_valid)
            npc = redir_target;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: state registers use non-blocking assignments so every update
            // within the block sees the values from before the edge.
            epc         <= '0;
            exl         <= 1'b0;
            pend_valid  <= 1'b0;
            pend_target <= '0;
        end else if (exc_take) begin
            epc        <= exc_epc;
            exl        <= 1'b1;
            pend_valid <= 1'b0;
        end else if (stall) begin
            // A later redirect in the same stall replaces the held target.
            if (redir_valid) begin
                pend_valid  <= 1'b1;
                pend_target <= redir_target;
            end
        end else begin
            if (eret_take)
                exl <= 1'b0;
            // The held target is either consumed now or dropped by eret.
            pend_valid <= 1'b0;
        end
    end

    assign redir_pend = pend_valid;

    // A fresh redirect in the cycle that consumes a held target is lost.
    redir_collision : assert property (@(posedge clk) disable iff (!reset)
        !(!exc_take && !stall && pend_valid && redir_valid));

endmodule

// File: tb/tb_npc_seq.sv
// Directed bench for npc_seq: a vector table run back to back,
// plus hand-written reset sequences.
module tb_npc_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc;
    logic        stall;
    logic        redir_valid;
    logic [31:0] redir_target;
    logic        exc;
    logic [31:0] exc_epc;
    logic        eret;
    logic [31:0] npc;
    logic [31:0] epc;
    logic        exl;
    logic        redir_pend;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    npc_seq dut (
        .clk          (clk),
        .reset        (reset),
        .pc           (pc),
        .stall        (stall),
        .redir_valid  (redir_valid),
        .redir_target (redir_target),
        .exc          (exc),
        .exc_epc      (exc_epc),
        .eret         (eret),
        .npc          (npc),
        .epc          (epc),
        .exl          (exl),
        .redir_pend   (redir_pend)
    );

    // Inputs for one cycle, plus the outputs expected before that cycle's edge.
    typedef struct {
        logic [31:0] pc;
        logic        stall;
        logic        rv;
        logic [31:0] rt;
        logic        exc;
        logic [31:0] eepc;
        logic        eret;
        logic [31:0] e_npc;
        logic        e_pend;
        logic        e_exl;
        logic [31:0] e_epc;
    } vec_t;

    localparam int NV = 20;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        stall        = 1'b0;
        redir_valid  = 1'b0;
        redir_target = '0;
        exc          = 1'b0;
        exc_epc      = '0;
        eret         = 1'b0;
    endtask

    initial begin
        //          pc            st rv rt            ex eepc          er  npc           pd xl epc
        vecs[0]  = '{32'h0000_3000, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0000_3004, 0, 0, 32'h0};
        vecs[1]  = '{32'h0000_3010, 0, 1, 32'h0000_3040, 0, 32'h0,         0, 32'h0000_3040, 0, 0, 32'h0};
        vecs[2]  = '{32'h0000_3040, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0000_3044, 0, 0, 32'h0};
        vecs[3]  = '{32'h0000_3020, 1, 1, 32'h0000_3100, 0, 32'h0,         0, 32'h0000_3020, 0, 0, 32'h0};
        vecs[4]  = '{32'h0000_3020, 1, 0, 32'h0,         0, 32'h0,         0, 32'h0000_3020, 1, 0, 32'h0};
        vecs[5]  = '{32'h0000_3020, 1, 1, 32'h0000_3104, 0, 32'h0,         0, 32'h0000_3020, 1, 0, 32'h0};
        vecs[6]  = '{32'h0000_3020, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0000_3104, 1, 0, 32'h0};
        vecs[7]  = '{32'h0000_3104, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0000_3108, 0, 0, 32'h0};
        vecs[8]  = '{32'h0000_3030, 1, 0, 32'h0,         1, 32'h0000_3024, 0, 32'h0000_4180, 0, 0, 32'h0};
        vecs[9]  = '{32'h0000_4180, 0, 0, 32'h0,         1, 32'h0000_5555, 0, 32'h0000_4184, 0, 1, 32'h0000_3024};
        vecs[10] = '{32'h0000_4184, 1, 0, 32'h0,         0, 32'h0,         1, 32'h0000_4184, 0, 1, 32'h0000_3024};
        vecs[11] = '{32'h0000_4184, 0, 0, 32'h0,         0, 32'h0,         1, 32'h0000_3024, 0, 1, 32'h0000_3024};
        vecs[12] = '{32'h0000_3024, 0, 0, 32'h0,         0, 32'h0,         1, 32'h0000_3028, 0, 0, 32'h0000_3024};
        vecs[13] = '{32'hFFFF_FFFC, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0000_0000, 0, 0, 32'h0000_3024};
        vecs[14] = '{32'h0000_0001, 0, 1, 32'h0000_3001, 0, 32'h0,         0, 32'h0000_3001, 0, 0, 32'h0000_3024};
        vecs[15] = '{32'h0000_3000, 1, 1, 32'h0000_3200, 1, 32'h0000_3008, 0, 32'h0000_4180, 0, 0, 32'h0000_3024};
        vecs[16] = '{32'h0000_4180, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0000_4184, 0, 1, 32'h0000_3008};
        vecs[17] = '{32'h0000_4184, 1, 1, 32'h0000_3300, 0, 32'h0,         0, 32'h0000_4184, 0, 1, 32'h0000_3008};
        vecs[18] = '{32'h0000_4184, 0, 0, 32'h0,         0, 32'h0,         1, 32'h0000_3008, 1, 1, 32'h0000_3008};
        vecs[19] = '{32'h0000_3008, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0000_300C, 0, 0, 32'h0000_3008};

        idle_inputs();
        pc    = 32'h0000_3000;
        reset = 1'b0;

        // Held in reset for three clocks.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("reset_npc", npc, 32'h0000_3000);
            check("reset_exl", {31'b0, exl}, 32'h0);
            check("reset_epc", epc, 32'h0);
            check("reset_pend", {31'b0, redir_pend}, 32'h0);
        end
        reset = 1'b1;

        for (int i = 0; i < NV; i++) begin
            pc           = vecs[i].pc;
            stall        = vecs[i].stall;
            redir_valid  = vecs[i].rv;
            redir_target = vecs[i].rt;
            exc          = vecs[i].exc;
            exc_epc      = vecs[i].eepc;
            eret         = vecs[i].eret;
            #2;
            check($sformatf("v%0d_npc", i), npc, vecs[i].e_npc);
            check($sformatf("v%0d_pend", i), {31'b0, redir_pend}, {31'b0, vecs[i].e_pend});
            check($sformatf("v%0d_exl", i), {31'b0, exl}, {31'b0, vecs[i].e_exl});
            check($sformatf("v%0d_epc", i), epc, vecs[i].e_epc);
            @(posedge clk);
            #1;
        end

        // Enter the handler, then reset asynchronously with no clock edge.
        idle_inputs();
        pc      = 32'h0000_3050;
        exc     = 1'b1;
        exc_epc = 32'h0000_3050;
        @(posedge clk);
        #1;
        idle_inputs();
        check("hdl_exl", {31'b0, exl}, 32'h1);
        check("hdl_epc", epc, 32'h0000_3050);
        #2;
        reset = 1'b0;
        #1;
        check("async_exl", {31'b0, exl}, 32'h0);
        check("async_epc", epc, 32'h0);
        check("async_npc", npc, 32'h0000_3000);
        @(posedge clk);
        #1;
        reset = 1'b1;
        pc    = 32'h0000_3000;
        #1;
        check("post_npc", npc, 32'h0000_3004);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
